// File: rtl/fir_mac_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_mac_controller: sequencing FSM for the FIR delay line, tap walk,      |
// | multiplier issue, accumulator and output handshake.                       |
// | Optional: FIR_CTRL_PERF_EN adds perf_samples / perf_stalls counters.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_mac_controller #(
  parameter int TAPS    = 8,
  parameter int MUL_LAT = 3,
  parameter int ADDR_W  = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              sr_load,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mul_valid,
  output logic              acc_clear,
  output logic              acc_load,
  output logic              out_load,
  output logic              busy
`ifdef FIR_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_samples,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int DRAIN_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_load  = 3'd1;
  localparam logic [2:0] c_mac   = 3'd2;
  localparam logic [2:0] c_drain = 3'd3;
  localparam logic [2:0] c_wb    = 3'd4;
  localparam logic [2:0] c_hold  = 3'd5;

  localparam logic [ADDR_W-1:0]  c_k_last     = ADDR_W'(TAPS - 1);
  localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'(MUL_LAT - 1);

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_k;
  logic [DRAIN_W-1:0] r_drain;
  logic [MUL_LAT-1:0] r_pipe;
  logic               w_accept;
  logic               w_out_hs;

  // in_ready is the only combinational output; it is gated by reset so the
  // source never sees a ready while the controller is held in reset.
  assign in_ready  = (r_state == c_idle) & reset;
  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;

  assign sr_load   = (r_state == c_load);
  assign acc_clear = (r_state == c_load);
  assign mul_valid = (r_state == c_mac);
  assign coef_addr = (r_state == c_mac) ? r_k : '0;
  assign out_load  = (r_state == c_wb);
  assign out_valid = (r_state == c_hold);
  assign busy      = (r_state != c_idle);
  assign acc_load  = r_pipe[MUL_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) r_state <= c_load;
        end
        c_load: begin
          r_k     <= '0;
          r_state <= c_mac;
        end
        c_mac: begin
          if (r_k == c_k_last) begin
            r_k     <= '0;
            r_drain <= '0;
            r_state <= c_drain;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        c_drain: begin
          if (r_drain == c_drain_last) begin
            r_drain <= '0;
            r_state <= c_wb;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        c_wb: begin
          r_state <= c_hold;
        end
        c_hold: begin
          if (out_ready) r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Issue-to-accumulate delay matches the multiplier pipeline depth exactly.
  generate
    if (MUL_LAT == 1) begin : g_pipe_one
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pipe <= '0;
        else        r_pipe <= mul_valid;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pipe <= '0;
        else        r_pipe <= {r_pipe[MUL_LAT-2:0], mul_valid};
      end
    end
  endgenerate

`ifdef FIR_CTRL_PERF_EN
  logic [31:0] r_perf_samples;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_samples <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_out_hs) r_perf_samples <= r_perf_samples + 32'd1;
      if (out_valid && !out_ready) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_samples = r_perf_samples;
  assign perf_stalls  = r_perf_stalls;
`else
  logic w_unused;
  assign w_unused = w_out_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_controller.sv
`default_nettype none
// Directed bench for fir_mac_controller (TAPS=8, MUL_LAT=3); perf counters
// are checked only when FIR_CTRL_PERF_EN is defined.
module tb_fir_mac_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic       sr_load;
  logic [2:0] coef_addr;
  logic       mul_valid;
  logic       acc_clear;
  logic       acc_load;
  logic       out_load;
  logic       busy;
`ifdef FIR_CTRL_PERF_EN
  logic [31:0] perf_samples;
  logic [31:0] perf_stalls;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_mac_controller #(.TAPS(8), .MUL_LAT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sr_load   (sr_load),
    .coef_addr (coef_addr),
    .mul_valid (mul_valid),
    .acc_clear (acc_clear),
    .acc_load  (acc_load),
    .out_load  (out_load),
    .busy      (busy)
`ifdef FIR_CTRL_PERF_EN
    ,
    .perf_samples (perf_samples),
    .perf_stalls  (perf_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {in_ready,out_valid,sr_load,acc_clear,mul_valid,acc_load,out_load,busy,coef_addr}
  function automatic logic [31:0] pack_outs();
    return {21'd0, in_ready, out_valid, sr_load, acc_clear, mul_valid,
            acc_load, out_load, busy, coef_addr};
  endfunction

  // Expected outputs for cycle c after an accept at cycle 0, out_ready held 0.
  function automatic logic [31:0] exp_outs(input int c);
    logic       mv;
    logic [2:0] ca;
    mv = (c >= 2 && c <= 9);
    ca = mv ? 3'(c - 2) : 3'd0;
    return {21'd0, 1'b0, (c >= 14), (c == 1), (c == 1), mv,
            (c >= 5 && c <= 12), (c == 13), 1'b1, ca};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gap;
    int first;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", pack_outs(), 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // Single sample, then 5 stall cycles in HOLD
    next_cycle();
    in_valid = 1'b1;
    @(negedge clk);
    check("accept0_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      in_valid = (c >= 14);
      @(negedge clk);
      check($sformatf("seq_c%0d", c), pack_outs(), exp_outs(c));
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_hs_valid", {31'd0, out_valid}, 32'd1);
    check("hold_hs_ready", {31'd0, in_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("idle_after_hs_ready", {31'd0, in_ready}, 32'd1);
    check("idle_after_hs_busy", {31'd0, busy}, 32'd0);
`ifdef FIR_CTRL_PERF_EN
    check("perf_stalls", perf_stalls, 32'd5);
    check("perf_samples1", perf_samples, 32'd1);
`endif

    // Back-to-back with in_valid and out_ready held high
    for (int n = 0; n < 2; n++) begin
      gap = 0;
      for (int c = 1; c <= 40 && gap == 0; c++) begin
        next_cycle();
        @(negedge clk);
        if (in_ready) gap = c;
        else if (c == 7) check("busy_mid", {30'd0, busy, in_ready}, 32'd2);
      end
      check($sformatf("accept_gap%0d", n), gap, 32'd15);
    end
    next_cycle();
    in_valid = 1'b0;
    first = 0;
    for (int c = 1; c <= 30 && first == 0; c++) begin
      next_cycle();
      @(negedge clk);
      if (!busy) first = c;
    end
    check("drain_to_idle", first, 32'd14);
`ifdef FIR_CTRL_PERF_EN
    check("perf_samples4", perf_samples, 32'd4);
`endif

    // Reset asserted mid-MAC
    next_cycle();
    in_valid = 1'b1;
    @(negedge clk);
    check("acc_r_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
    end
    check("mid_mac_addr", {29'd0, coef_addr}, 32'd3);
    next_cycle();
    reset = 1'b0;
    #1;
    check("mid_reset_outs", pack_outs(), 32'd0);
`ifdef FIR_CTRL_PERF_EN
    check("mid_reset_perf", perf_samples | perf_stalls, 32'd0);
`endif
    next_cycle();
    @(negedge clk);
    check("reset_hold_outs", pack_outs(), 32'd0);
    next_cycle();
    reset    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {31'd0, in_ready}, 32'd1);
    first = 0;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) first = c;
    end
    check("post_reset_latency", first, 32'd14);
    next_cycle();
    @(negedge clk);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
